// File: rtl/lcd_timing_engine.sv
// lcd_timing_engine: pixel-clock timing generator for TFT panels.
// Issues framebuffer fetch requests ahead of display, then delays HS/VS/DE
// so they line up with read data returned FETCH_LAT cycles later.
// Enable is sampled only at the frame boundary; frames are counted.
module lcd_timing_engine #(
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 72,
  parameter int H_BACK    = 96,
  parameter int H_ACT     = 800,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 10,
  parameter int V_BACK    = 7,
  parameter int V_ACT     = 480,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int FETCH_LAT = 2,
  parameter int CW        = 11,
  parameter int ADDR_W    = 22
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iEnable,
  input  logic [7:0]        iRed,
  input  logic [7:0]        iGreen,
  input  logic [7:0]        iBlue,
  output logic              oRequest,
  output logic [ADDR_W-1:0] oAddress,
  output logic [CW-1:0]     oCurrent_X,
  output logic [CW-1:0]     oCurrent_Y,
  output logic              oFrameStart,
  output logic [15:0]       oFrameCount,
  output logic [7:0]        oLCD_R,
  output logic [7:0]        oLCD_G,
  output logic [7:0]        oLCD_B,
  output logic              oLCD_HS,
  output logic              oLCD_VS,
  output logic              oLCD_DE
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_ACT;
  localparam int D       = FETCH_LAT + 1;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BL   = CW'(H_BLANK);
  localparam logic [CW-1:0] V_BL   = CW'(V_BLANK);
  localparam logic [CW-1:0] HS_BEG = CW'(H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_FRONT + V_SYNC);

  logic [CW-1:0]     h, v;
  logic              en_q;
  logic              line_end, frame_end;
  logic              act, req, hs_a, vs_a, de_a;
  logic [D-1:0]      hs_sr, vs_sr, de_sr;
  logic              de_dly;
  logic [7:0]        r_q, g_q, b_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       frame_cnt;

  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);

  // Horizontal / vertical position counters
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + CW'(1);
    end else begin
      h <= h + CW'(1);
    end
  end

  // Enable latch and frame counter, both updated only at the frame boundary
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      en_q      <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_end) begin
      en_q      <= iEnable;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign act  = (h >= H_BL) && (v >= V_BL);
  assign req  = act && en_q;
  assign hs_a = (h >= HS_BEG) && (h < HS_END);
  assign vs_a = (v >= VS_BEG) && (v < VS_END);
  assign de_a = req;

  assign oRequest    = req;
  assign oCurrent_X  = req ? (h - H_BL) : '0;
  assign oCurrent_Y  = req ? (v - V_BL) : '0;
  assign oFrameStart = (h == '0) && (v == '0);
  assign oFrameCount = frame_cnt;
  assign oAddress    = addr_q;

  // Linear pixel address: raster order means a running count equals y*H_ACT+x
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      addr_q <= '0;
    end else if (oFrameStart) begin
      addr_q <= '0;
    end else if (req) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // Sync/DE delay line of depth FETCH_LAT+1
  generate
    if (D > 1) begin : g_sr_deep
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          hs_sr <= '0;
          vs_sr <= '0;
          de_sr <= '0;
        end else begin
          hs_sr <= {hs_sr[D-2:0], hs_a};
          vs_sr <= {vs_sr[D-2:0], vs_a};
          de_sr <= {de_sr[D-2:0], de_a};
        end
      end
    end else begin : g_sr_single
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          hs_sr <= '0;
          vs_sr <= '0;
          de_sr <= '0;
        end else begin
          hs_sr <= hs_a;
          vs_sr <= vs_a;
          de_sr <= de_a;
        end
      end
    end
  endgenerate

  // DE delayed by FETCH_LAT marks the cycle the requested pixel arrives;
  // with zero latency the data arrives on the request cycle itself
  generate
    if (FETCH_LAT == 0) begin : g_tap_now
      assign de_dly = de_a;
    end else begin : g_tap_sr
      assign de_dly = de_sr[FETCH_LAT-1];
    end
  endgenerate

  // Pixel output register, blanked outside the data-enable window
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (de_dly) begin
      r_q <= iRed;
      g_q <= iGreen;
      b_q <= iBlue;
    end else begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end
  end

  assign oLCD_R  = r_q;
  assign oLCD_G  = g_q;
  assign oLCD_B  = b_q;
  assign oLCD_DE = de_sr[D-1];
  assign oLCD_HS = (HS_POL != 0) ? hs_sr[D-1] : ~hs_sr[D-1];
  assign oLCD_VS = (VS_POL != 0) ? vs_sr[D-1] : ~vs_sr[D-1];

endmodule
